// File: rtl/uart_rxd.sv
// UART receiver: 8N1 or 8-bit-plus-parity frames sampled at mid-bit, byte presented
// zero-extended on a 16-bit register with a ready/acknowledge handshake and status flags.
module uart_rxd #(
    parameter logic [15:0] BIT_TICKS = 16'h0364
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rxd,
    input  logic        parity_en,
    input  logic        parity_kind,
    input  logic        rd_ack,
    output logic [15:0] rx_data,
    output logic        rdy,
    output logic        parity_err,
    output logic        frame_err,
    output logic        overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    localparam logic [15:0] HALF_TERM = (BIT_TICKS >> 1) - 16'd1;
    localparam logic [15:0] FULL_TERM = BIT_TICKS - 16'd1;

    logic        rx_meta_q;
    logic        rxs_q;
    logic        rxs_prev_q;

    state_e      state_q, state_d;
    logic [15:0] tick_q, tick_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        pen_q, pen_d;
    logic        pkind_q, pkind_d;
    logic        par_bit_q, par_bit_d;
    logic [7:0]  data_q, data_d;
    logic        rdy_q, rdy_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;

    logic [15:0] terminal;
    logic        sample;
    logic        fall;
    logic        parity_exp;
    logic        mismatch;

    // Synchroniser and edge history idle high so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value,
            // which is what makes this a two-stage synchroniser rather than a wire.
            rx_meta_q  <= rxd;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tick_q    <= 16'd0;
            bit_cnt_q <= 3'd0;
            // NOTE: the datapath is reset along with the FSM so a reset mid-frame
            // leaves no partial byte or stale parity sample behind.
            shift_q   <= 8'd0;
            pen_q     <= 1'b0;
            pkind_q   <= 1'b0;
            par_bit_q <= 1'b0;
            data_q    <= 8'd0;
            rdy_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            pen_q     <= pen_d;
            pkind_q   <= pkind_d;
            par_bit_q <= par_bit_d;
            data_q    <= data_d;
            rdy_q     <= rdy_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign terminal   = (state_q == S_START) ? HALF_TERM : FULL_TERM;
    assign sample     = (state_q != S_IDLE) && (tick_q == terminal);
    assign fall       = rxs_prev_q & ~rxs_q;
    assign parity_exp = (^shift_q) ^ pkind_q;
    assign mismatch   = pen_q & (par_bit_q != parity_exp);

    always_comb begin
        // NOTE: every next-state signal gets a hold/default value first; a path that
        // leaves one unassigned would otherwise infer a latch.
        state_d   = state_q;
        tick_d    = tick_q + 16'd1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pen_d     = pen_q;
        pkind_d   = pkind_q;
        par_bit_d = par_bit_q;
        data_d    = data_q;
        rdy_d     = rdy_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        ovr_d     = ovr_q;

        if (rd_ack) begin
            rdy_d  = 1'b0;
            perr_d = 1'b0;
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                tick_d = 16'd0;
                if (fall) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (sample) begin
                    if (rxs_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        pen_d     = parity_en;
                        pkind_d   = parity_kind;
                        bit_cnt_d = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (sample) begin
                    shift_d   = {rxs_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = pen_q ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (sample) begin
                    par_bit_d = rxs_q;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (sample) begin
                    // A completing frame overrides a simultaneous acknowledge.
                    data_d  = shift_q;
                    rdy_d   = 1'b1;
                    ferr_d  = ~rxs_q;
                    perr_d  = mismatch;
                    ovr_d   = ~rd_ack & (ovr_q | rdy_q);
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Each sample point is a fresh entry into the (possibly same) state.
        if (sample) begin
            tick_d = 16'd0;
        end
    end

    assign rx_data    = {8'h00, data_q};
    assign rdy        = rdy_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule
